// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared display constants: segment width, hex glyphs (gfedcba, active-high) and digit-enable idle value.
// Optional leading-zero blanking in ssd_scan_ctrl is enabled by defining SSD_LZ_BLANK_EN.
`ifndef SSD_SCAN_CTRL_DEFS
`define SSD_SCAN_CTRL_DEFS
`define SSD_BIT_WIDTH 7
`define SS_0 7'h3F
`define SS_1 7'h06
`define SS_2 7'h5B
`define SS_3 7'h4F
`define SS_4 7'h66
`define SS_5 7'h6D
`define SS_6 7'h7D
`define SS_7 7'h07
`define SS_8 7'h7F
`define SS_9 7'h6F
`define SS_A 7'h77
`define SS_B 7'h7C
`define SS_C 7'h39
`define SS_D 7'h5E
`define SS_E 7'h79
`define SS_F 7'h71
`define SS_DEF 7'h40
`define SSD_CTL_OFF 4'b1111
`endif

package ssd_scan_ctrl_pkg;
  localparam int NIB_W       = 4;
  localparam int DIG_W       = 2;
  localparam int NUM_DIG_REQ = 4;
  localparam logic [3:0] CTL_OFF = `SSD_CTL_OFF;
endpackage

// File: rtl/display.sv
// 4-bit to segment decoder; pure combinational lookup of the hex glyph table.
module display
  import ssd_scan_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0]          nib,
  output logic [`SSD_BIT_WIDTH-1:0] seg
);

  always_comb begin
    case (nib)
      4'h0:    seg = `SS_0;
      4'h1:    seg = `SS_1;
      4'h2:    seg = `SS_2;
      4'h3:    seg = `SS_3;
      4'h4:    seg = `SS_4;
      4'h5:    seg = `SS_5;
      4'h6:    seg = `SS_6;
      4'h7:    seg = `SS_7;
      4'h8:    seg = `SS_8;
      4'h9:    seg = `SS_9;
      4'hA:    seg = `SS_A;
      4'hB:    seg = `SS_B;
      4'hC:    seg = `SS_C;
      4'hD:    seg = `SS_D;
      4'hE:    seg = `SS_E;
      4'hF:    seg = `SS_F;
      default: seg = `SS_DEF;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit time-multiplexed display scanner with frame-boundary shadow update.
// Define SSD_LZ_BLANK_EN to blank leading-zero digits 3..1.
module ssd_scan_ctrl
  import ssd_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_W = 17,
  parameter int NUM_DIG   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [15:0]               value,
  input  logic                      load,
  input  logic [3:0]                digit_en,
  output logic                      upd_pend,
  output logic                      frame_tick,
  output logic [DIG_W-1:0]          cur_digit,
  output logic [3:0]                ssd_ctl,
  output logic [`SSD_BIT_WIDTH-1:0] segs
);

  generate
    if (NUM_DIG != NUM_DIG_REQ) begin : g_bad_num_dig
      $error("ssd_scan_ctrl supports exactly 4 digits");
    end
  endgenerate

  logic [REFRESH_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0]     cur_digit_q, cur_digit_d;
  logic [15:0]          shadow_q, shadow_d;
  logic [15:0]          pend_val_q, pend_val_d;
  logic                 upd_pend_q, upd_pend_d;
  logic                 slot_tick, boundary;
  logic [NIB_W-1:0]     nib;
  logic                 show;

  assign slot_tick = &cnt_q;
  assign boundary  = slot_tick && (cur_digit_q == DIG_W'(NUM_DIG_REQ - 1));

  always_comb begin
    cnt_d       = cnt_q + REFRESH_W'(1);
    cur_digit_d = slot_tick ? cur_digit_q + DIG_W'(1) : cur_digit_q;
    shadow_d    = shadow_q;
    pend_val_d  = pend_val_q;
    upd_pend_d  = upd_pend_q;
    // A load landing on the boundary bypasses the pending register entirely.
    if (boundary) begin
      if (load) begin
        shadow_d   = value;
        upd_pend_d = 1'b0;
      end else if (upd_pend_q) begin
        shadow_d   = pend_val_q;
        upd_pend_d = 1'b0;
      end
    end else if (load) begin
      pend_val_d = value;
      upd_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      cur_digit_q <= '0;
      shadow_q    <= '0;
      pend_val_q  <= '0;
      upd_pend_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_digit_q <= cur_digit_d;
      shadow_q    <= shadow_d;
      pend_val_q  <= pend_val_d;
      upd_pend_q  <= upd_pend_d;
    end
  end

  assign nib = shadow_q[{cur_digit_q, 2'b00} +: NIB_W];

`ifdef SSD_LZ_BLANK_EN
  // lz_zero[k]: nibbles k..3 of the shadow are all zero.
  logic [3:0] lz_zero;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lz
    assign lz_zero[gi] = ~|shadow_q[15:4*gi];
  end
  assign show = digit_en[cur_digit_q] && !((cur_digit_q != '0) && lz_zero[cur_digit_q]);
`else
  assign show = digit_en[cur_digit_q];
`endif

  assign ssd_ctl    = show ? ~(4'b0001 << cur_digit_q) : CTL_OFF;
  assign upd_pend   = upd_pend_q;
  assign frame_tick = boundary;
  assign cur_digit  = cur_digit_q;

  display u_display (
    .nib (nib),
    .seg (segs)
  );

endmodule
